// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// The FSM state encoding, RV32I load/store Funct3 codes and the alignment
// check live here so the top and the formatter use the same decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords need a[0]=0 and words need a[1:0]=00; bytes are always aligned.
    // Reserved Funct3 codes fall into the word case.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr);
        logic mis;
        case (funct3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = addr[0];
            default:     mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_format.sv
// Purely combinational data formatting for the load/store unit.
// Store side: steers rs2 onto byte lanes and builds the byte enables.
// Load side: picks the addressed byte/half from the bus word and extends it.
// Address bits below the access size are ignored (LH at 01 uses lanes 0-1).
module lsu_format
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Store lane steering: replicate the datum so any enabled lane sees it.
    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_addr_lo;
            end
            F3_H, F3_HU: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = st_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        byte_sh = ld_rdata >> {ld_addr_lo, 3'b000};
        half_sh = ld_rdata >> {ld_addr_lo[1], 4'b0000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   ld_data = {24'h0, byte_sh[7:0]};
            F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   ld_data = {16'h0, half_sh[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns the datapath's MemRead/MemWrite into a registered
// request/acknowledge bus access and stalls the core until it completes.
// IDLE -> BUSY (wait for MemAck or timeout) -> DONE (one commit cycle) -> IDLE.
// Optional build macro: LSU_MISALIGN_TRAP_EN adds MisalignTrap and turns
// misaligned halfword/word accesses into a bus-less trap completion.
// Bus handshake: MemReq rises when an access is issued and stays high with
// address/data/enables stable until the cycle after MemAck (a single-cycle
// pulse) or until the timeout; MemAck seen while not BUSY is ignored.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData,
    output logic            Stall,
    output logic            BusErr,
    output logic            MemReq,
    output logic            MemWe,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] MemWData,
    output logic [3:0]      MemBe,
    input  logic            MemAck,
    input  logic [XLEN-1:0] MemRData,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic            MisalignTrap,
`endif
    output logic [1:0]      dbg_state
);

    lsu_state_t  state;
    logic [7:0]  cnt;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_addr_lo;
    logic        lat_load;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_rdata;
    logic        access;

    assign access    = MemRead | MemWrite;
    assign Stall     = access && (state != DONE);
    assign dbg_state = state;

    lsu_format u_format (
        .st_funct3  (Funct3),
        .st_addr_lo (ALUResult[1:0]),
        .st_data    (WriteData),
        .st_wdata   (fmt_wdata),
        .st_be      (fmt_be),
        .ld_funct3  (lat_funct3),
        .ld_addr_lo (lat_addr_lo),
        .ld_rdata   (MemRData),
        .ld_data    (fmt_rdata)
    );

    // Access FSM with the timeout counter and all bus-facing registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
            MemBe       <= 4'b0000;
            ReadData    <= '0;
            BusErr      <= 1'b0;
            lat_funct3  <= 3'b000;
            lat_addr_lo <= 2'b00;
            lat_load    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            MisalignTrap <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(Funct3, ALUResult[1:0])) begin
                            ReadData     <= '0;
                            MisalignTrap <= 1'b1;
                            state        <= DONE;
                        end else begin
`endif
                            MemAddr     <= {ALUResult[XLEN-1:2], 2'b00};
                            MemWData    <= fmt_wdata;
                            MemBe       <= fmt_be;
                            MemWe       <= MemWrite;
                            MemReq      <= 1'b1;
                            cnt         <= 8'd0;
                            lat_funct3  <= Funct3;
                            lat_addr_lo <= ALUResult[1:0];
                            lat_load    <= MemRead;
                            state       <= BUSY;
`ifdef LSU_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                BUSY: begin
                    if (MemAck) begin
                        MemReq   <= 1'b0;
                        ReadData <= lat_load ? fmt_rdata : '0;
                        state    <= DONE;
                    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        MemReq   <= 1'b0;
                        ReadData <= '0;
                        BusErr   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    BusErr <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    MisalignTrap <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusErr;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBe;
    logic        MemAck;
    logic [31:0] MemRData;
    logic [1:0]  dbg_state;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        MisalignTrap;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemBe     (MemBe),
        .MemAck    (MemAck),
        .MemRData  (MemRData),
`ifdef LSU_MISALIGN_TRAP_EN
        .MisalignTrap (MisalignTrap),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One memory instruction with MemAck in the first BUSY cycle.
    task automatic run_access(input string tag, input logic is_wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                              input logic [31:0] exp_rd);
        exp_q.push_back(exp_rd);
        MemRead   = !is_wr;
        MemWrite  = is_wr;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wdata;
        #1;
        check({tag, "_stall_idle"}, 32'(Stall), 32'd1);
        @(posedge clk); #1;
        check({tag, "_req"}, 32'(MemReq), 32'd1);
        check({tag, "_addr"}, MemAddr, exp_addr);
        check({tag, "_be"}, 32'(MemBe), 32'(exp_be));
        check({tag, "_we"}, 32'(MemWe), 32'(is_wr));
        if (is_wr) check({tag, "_wdata"}, MemWData, exp_wdata);
        check({tag, "_stall_busy"}, 32'(Stall), 32'd1);
        MemAck   = 1'b1;
        MemRData = rdata;
        @(posedge clk); #1;
        MemAck   = 1'b0;
        MemRData = 32'h0;
        check({tag, "_req_done"}, 32'(MemReq), 32'd0);
        check({tag, "_stall_done"}, 32'(Stall), 32'd0);
        check({tag, "_rdata"}, ReadData, exp_q.pop_front());
        check({tag, "_buserr"}, 32'(BusErr), 32'd0);
        @(posedge clk); #1;
        check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        int cyc;
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        MemAck    = 1'b0;
        MemRData  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(MemReq), 32'd0);
        check("rst_addr", MemAddr, 32'h0);
        check("rst_be", 32'(MemBe), 32'd0);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_buserr", 32'(BusErr), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("nomem_stall", 32'(Stall), 32'd0);

        //          tag    wr    f3      addr          wdata         rdata         exp_addr      exp_wdata     be       exp_rd
        run_access("sw",   1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        run_access("lb",   1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h80FF_1234, 32'h0000_0200, 32'h0,        4'b1000, 32'hFFFF_FF80);
        run_access("lbu",  1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80FF_1234, 32'h0000_0200, 32'h0,        4'b1000, 32'h0000_0080);
        run_access("lhu",  1'b0, 3'b101, 32'h0000_0022, 32'h0,         32'hBEEF_0000, 32'h0000_0020, 32'h0,        4'b1100, 32'h0000_BEEF);
        run_access("lh",   1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'hBEEF_0000, 32'h0000_0020, 32'h0,        4'b1100, 32'hFFFF_BEEF);
        run_access("sb",   1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 32'h5555_5555, 32'h0000_0010, 32'hABAB_ABAB, 4'b0010, 32'h0);
        run_access("sh",   1'b1, 3'b001, 32'h0000_0012, 32'h0000_5678, 32'h0,        32'h0000_0010, 32'h5678_5678, 4'b1100, 32'h0);
        run_access("rsv",  1'b0, 3'b011, 32'h0000_0030, 32'h0,         32'h1122_3344, 32'h0000_0030, 32'h0,        4'b1111, 32'h1122_3344);
`ifndef LSU_MISALIGN_TRAP_EN
        run_access("lhmis", 1'b0, 3'b001, 32'h0000_0021, 32'h0,        32'h1234_8765, 32'h0000_0020, 32'h0,        4'b0011, 32'hFFFF_8765);
        run_access("lwmis", 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'hCAFE_F00D, 32'h0000_0100, 32'h0,        4'b1111, 32'hCAFE_F00D);
`endif
        run_access("lw",   1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'h1357_9BDF, 32'h0000_0104, 32'h0,        4'b1111, 32'h1357_9BDF);

`ifdef LSU_MISALIGN_TRAP_EN
        // Misaligned word: no bus request, straight to a trap DONE cycle.
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0102;
        #1;
        check("trap_stall_idle", 32'(Stall), 32'd1);
        @(posedge clk); #1;
        check("trap_req", 32'(MemReq), 32'd0);
        check("trap_flag", 32'(MisalignTrap), 32'd1);
        check("trap_state", 32'(dbg_state), 32'd2);
        check("trap_rdata", ReadData, 32'h0);
        check("trap_stall_done", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check("trap_clear", 32'(MisalignTrap), 32'd0);
        check("trap_req_after", 32'(MemReq), 32'd0);
        MemRead = 1'b0;
        run_access("lw2", 1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'h2468_ACE0, 32'h0000_0108, 32'h0, 4'b1111, 32'h2468_ACE0);
`endif

        // Timeout: no ack; MemReq must drop after 4 BUSY cycles.
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0040;
        @(posedge clk); #1;
        check("to_req", 32'(MemReq), 32'd1);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!MemReq) break;
        end
        check("to_cycles", 32'(cyc), 32'd4);
        check("to_buserr", 32'(BusErr), 32'd1);
        check("to_rdata", ReadData, 32'h0);
        check("to_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        check("to_buserr_clr", 32'(BusErr), 32'd0);
        check("to_state", 32'(dbg_state), 32'd0);
        MemRead = 1'b0;

        // Load a nonzero value so the reset test can see ReadData cleared.
        run_access("lw3", 1'b0, 3'b010, 32'h0000_0050, 32'h0, 32'h0F0F_0F0F, 32'h0000_0050, 32'h0, 4'b1111, 32'h0F0F_0F0F);

        // Reset in the middle of BUSY, then a late ack.
        MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h0000_0060;
        @(posedge clk); #1;
        check("rb_req", 32'(MemReq), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rb_req_drop", 32'(MemReq), 32'd0);
        check("rb_state", 32'(dbg_state), 32'd0);
        check("rb_rdata", ReadData, 32'h0);
        MemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        MemAck = 1'b1; MemRData = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        MemAck = 1'b0; MemRData = 32'h0;
        check("rb_late_rdata", ReadData, 32'h0);
        check("rb_late_state", 32'(dbg_state), 32'd0);
        check("rb_late_req", 32'(MemReq), 32'd0);
        check("rb_late_stall", 32'(Stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Downstream neighbour of the single-cycle datapath. Consumes ALUResult (address), WriteData, and control MemRead/MemWrite/Funct3. Returns the formatted ReadData.
- Replaces the ideal zero-latency data memory with a request/acknowledge data bus. It stalls the core (freezes PC and register writes) until the access completes.
- Handles byte/halfword lane steering, sign/zero extension and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 64, BUSY-state cycles without MemAck before the access is abandoned (legal range 2..255).
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- MemRead  input  1  load in current instruction.
- MemWrite  input  1  store in current instruction; never asserted together with MemRead.
- Funct3  input  3  access size/sign (RV32I load/store encoding).
- ALUResult  input  32  byte address.
- WriteData  input  32  store source (rs2).
- ReadData  output  32  formatted load result to datapath.
- Stall  output  1  core must hold PC and suppress RegWrite.
- BusErr  output  1  one-cycle pulse: access timed out.
- MemReq  output  1  bus request, registered.
- MemWe  output  1  bus write, registered.
- MemAddr  output  32  word-aligned bus address (bits[1:0]=00), registered.
- MemWData  output  32  lane-steered store data, registered.
- MemBe  output  4  byte enables, registered.
- MemAck  input  1  bus completion, single-cycle pulse.
- MemRData  input  32  bus read data, valid with MemAck.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemBe=0.
  - ReadData=0, BusErr=0, timeout counter=0.
  - Asserting reset mid-access drops MemReq immediately. The outstanding access is abandoned and a late MemAck is ignored.
- FSM states: IDLE, BUSY, DONE.
- Stall is combinational: (MemRead|MemWrite) && state!=DONE.
- IDLE:
  - On MemRead|MemWrite, register MemAddr={ALUResult[31:2],2'b00}, MemBe, MemWData and MemWe=MemWrite; set MemReq=1; clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - MemReq and the address/data/enables are held stable.
  - On MemAck: MemReq=0; load data is captured into ReadData (stores leave ReadData=0); go to DONE.
  - With no ack: counter++. When counter==TIMEOUT_CYCLES-1: MemReq=0, ReadData=0, BusErr=1 for the DONE cycle, go to DONE.
- DONE: Stall=0 for exactly one cycle so the core commits; BusErr clears; go to IDLE.
  - If the next instruction is also a memory access, it is detected in IDLE the following cycle.
  - Back-to-back accesses therefore cost a minimum of 3 cycles each.
- Minimum latency: IDLE→BUSY (ack in the first BUSY cycle)→DONE = 3 cycles per memory instruction. Non-memory instructions take 1 cycle and never stall.
- Store lanes, from ALUResult[1:0]:
  - SB (000): byte replicated ×4, MemBe=1<<a[1:0].
  - SH (001): half replicated ×2, MemBe=a[1]?1100:0011.
  - SW (010): MemBe=1111.
- Load extract from MemRData using the latched low address bits:
  - LB (000) / LBU (100): selected byte, sign- or zero-extended.
  - LH (001) / LHU (101): selected half, sign- or zero-extended.
  - LW (010): full word.
- Reserved Funct3 (011, 110, 111) is treated as a word access.
- Misaligned access without the optional feature: the low address bits beyond the access size are ignored. LH at a[1:0]=01 uses lanes 0-1; LW ignores a[1:0].
- A MemAck arriving in IDLE or DONE is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output MisalignTrap (1 bit, reset 0).
  - A halfword access with a[0]=1, or a word access with a[1:0]!=00, issues no bus request. IDLE goes directly to DONE with ReadData=0 and MisalignTrap=1 for that DONE cycle.
- When undefined: no port is added, and misaligned accesses follow the lane-ignore rule above.

Decomposition:
- Package lsu_pkg:
  - State enum lsu_state_t {IDLE, BUSY, DONE}.
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function is_misaligned(funct3, addr[1:0]).
- One natural sub-module, lsu_format (purely combinational):
  - Store lane steering / MemBe generation.
  - Load extraction / extension.
- The FSM, timeout counter and bus registers stay in load_store_unit.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF, ack in the first BUSY cycle → MemAddr 0x100, MemBe 1111, MemWData 0xDEADBEEF, MemWe=1; Stall high 2 cycles, low in DONE.
- LB: addr 0x203, MemRData 0x80FF_1234 → MemAddr 0x200, ReadData 0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- LHU: addr 0x22, MemRData 0xBEEF_0000 → ReadData 0x0000BEEF. LH with the same stimulus → 0xFFFFBEEF.
- SB: addr 0x11, data 0x000000AB → MemBe 0010, MemWData 0xABABABAB.
- Timeout: load with MemAck never asserted, TIMEOUT_CYCLES=4 → MemReq drops after 4 BUSY cycles; BusErr=1 for one cycle; ReadData=0; Stall releases.
- Reset mid-BUSY: assert reset=0, then send MemAck after release → MemReq=0 immediately, state IDLE, ack ignored, ReadData=0. With LSU_MISALIGN_TRAP_EN: LW at 0x102 → MemReq never asserted, MisalignTrap=1 one cycle after issue.
